// File: rtl/bist_response_checker_if.sv
`default_nettype none
// ============================================================================
// bist_response_checker_if : scan-out / golden-ROM / verdict bundle
// Rev 1.0 : initial release
// ============================================================================
interface bist_response_checker_if #(
   parameter int PSUM_W     = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_W      = 5
);
   logic                  clr;
   logic                  out_valid;
   logic [PSUM_W-1:0]     scan_word;
   logic [ADDR_WIDTH-1:0] pattern_addr;
   logic [CNT_W-1:0]      exp_idx;
   logic [PSUM_W-1:0]     exp_word;
   logic                  compare;
   logic                  compare_fail;
   logic                  fail_seen;
   logic [ADDR_WIDTH-1:0] first_fail_addr;
   logic [CNT_W-1:0]      first_fail_idx;
   logic [7:0]            fail_cnt;

   modport master (
      output clr, out_valid, scan_word, pattern_addr, exp_word, compare,
      input  exp_idx, compare_fail, fail_seen, first_fail_addr, first_fail_idx, fail_cnt
   );

   modport slave (
      input  clr, out_valid, scan_word, pattern_addr, exp_word, compare,
      output exp_idx, compare_fail, fail_seen, first_fail_addr, first_fail_idx, fail_cnt
   );
endinterface
`default_nettype wire

// File: rtl/bist_response_checker.sv
`default_nettype none
// ============================================================================
// bist_response_checker : compares scan-out partial sums against golden ROM
// Rev 1.0 : initial release
// ============================================================================
module bist_response_checker #(
   parameter int SCAN_LENGTH = 16,
   parameter int PSUM_W      = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int CNT_W       = $clog2(SCAN_LENGTH + 1)
) (
   input  wire logic               clk,
   input  wire logic               rst,
   bist_response_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SCAN_LENGTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_LENGTH - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  mismatch_q, mismatch_d;
   logic                  overrun_q, overrun_d;
   logic [CNT_W-1:0]      pend_idx_q, pend_idx_d;
   logic                  fail_seen_q, fail_seen_d;
   logic [7:0]            fail_cnt_q, fail_cnt_d;
   logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
   logic [CNT_W-1:0]      first_idx_q, first_idx_d;

   logic w_word_mm;
   logic w_verdict_fail;

   assign w_word_mm = (bus.scan_word != bus.exp_word);

   // A word arriving alongside compare is discarded and judged as an overrun.
   assign w_verdict_fail = mismatch_q | overrun_q | (count_q != FULL_CNT) | bus.out_valid;

   assign bus.compare_fail    = bus.compare & w_verdict_fail;
   assign bus.exp_idx         = count_q;
   assign bus.fail_seen       = fail_seen_q;
   assign bus.fail_cnt        = fail_cnt_q;
   assign bus.first_fail_addr = first_addr_q;
   assign bus.first_fail_idx  = first_idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         mismatch_q   <= 1'b0;
         overrun_q    <= 1'b0;
         pend_idx_q   <= '0;
         fail_seen_q  <= 1'b0;
         fail_cnt_q   <= '0;
         first_addr_q <= '0;
         first_idx_q  <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         mismatch_q   <= mismatch_d;
         overrun_q    <= overrun_d;
         pend_idx_q   <= pend_idx_d;
         fail_seen_q  <= fail_seen_d;
         fail_cnt_q   <= fail_cnt_d;
         first_addr_q <= first_addr_d;
         first_idx_q  <= first_idx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      mismatch_d   = mismatch_q;
      overrun_d    = overrun_q;
      pend_idx_d   = pend_idx_q;
      fail_seen_d  = fail_seen_q;
      fail_cnt_d   = fail_cnt_q;
      first_addr_d = first_addr_q;
      first_idx_d  = first_idx_q;

      if (bus.clr) begin
         state_d      = IDLE;
         count_d      = '0;
         mismatch_d   = 1'b0;
         overrun_d    = 1'b0;
         pend_idx_d   = '0;
         fail_seen_d  = 1'b0;
         fail_cnt_d   = '0;
         first_addr_d = '0;
         first_idx_d  = '0;
      end else if (bus.compare) begin
         state_d    = IDLE;
         count_d    = '0;
         mismatch_d = 1'b0;
         overrun_d  = 1'b0;
         pend_idx_d = '0;
         if (w_verdict_fail) begin
            if (fail_cnt_q != 8'hFF) begin
               fail_cnt_d = fail_cnt_q + 8'd1;
            end
            fail_seen_d = 1'b1;
            if (!fail_seen_q) begin
               first_addr_d = bus.pattern_addr;
               first_idx_d  = mismatch_q ? pend_idx_q : FULL_CNT;
            end
         end
      end else if (bus.out_valid) begin
         if (state_q == FULL) begin
            overrun_d = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
            state_d = (count_q == LAST_CNT) ? FULL : COLLECT;
            if (w_word_mm) begin
               mismatch_d = 1'b1;
               if (!mismatch_q) begin
                  pend_idx_d = count_q;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bist_response_checker.sv
`default_nettype none
// ============================================================================
// tb_bist_response_checker : directed self-checking bench for the checker
// Rev 1.0 : initial release
// ============================================================================
module tb_bist_response_checker;

   localparam int SL    = 16;
   localparam int CNT_W = 5;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bist_response_checker_if #(.PSUM_W(16), .ADDR_WIDTH(4), .CNT_W(CNT_W)) bus ();

   bist_response_checker #(
      .SCAN_LENGTH(SL),
      .PSUM_W     (16),
      .ADDR_WIDTH (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic logic [15:0] golden(input logic [3:0] a, input logic [4:0] i);
      return {a, 7'h2B, i} ^ 16'h9C31;
   endfunction

   // Combinational golden ROM addressed by the DUT's word index
   assign bus.exp_word = golden(bus.pattern_addr, bus.exp_idx);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic send_word(input logic [3:0] addr, input int idx, input bit bad);
      @(negedge clk);
      bus.out_valid    = 1'b1;
      bus.pattern_addr = addr;
      bus.scan_word    = golden(addr, 5'(idx)) ^ (bad ? 16'h0101 : 16'h0000);
      @(posedge clk);
      #1 bus.out_valid = 1'b0;
   endtask

   task automatic do_compare(input logic [3:0] addr, input bit with_valid, output logic cf);
      @(negedge clk);
      bus.compare      = 1'b1;
      bus.out_valid    = with_valid;
      bus.pattern_addr = addr;
      bus.scan_word    = 16'h0000;
      #1 cf = bus.compare_fail;
      @(posedge clk);
      #1;
      bus.compare   = 1'b0;
      bus.out_valid = 1'b0;
   endtask

   task automatic do_clr();
      @(negedge clk);
      bus.clr = 1'b1;
      @(posedge clk);
      #1 bus.clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.clr = 1'b0; bus.out_valid = 1'b0; bus.compare = 1'b0;
      bus.scan_word = '0; bus.pattern_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.exp_idx !== 5'd0) begin errors++; $display("FAIL rst_exp_idx got %0d want 0", bus.exp_idx); end
      checks++; if (bus.fail_seen !== 1'b0) begin errors++; $display("FAIL rst_fail_seen got %0b want 0", bus.fail_seen); end
      checks++; if (bus.fail_cnt !== 8'd0) begin errors++; $display("FAIL rst_fail_cnt got %0d want 0", bus.fail_cnt); end
      checks++; if (bus.first_fail_addr !== 4'd0) begin errors++; $display("FAIL rst_first_addr got %0d want 0", bus.first_fail_addr); end
      checks++; if (bus.first_fail_idx !== 5'd0) begin errors++; $display("FAIL rst_first_idx got %0d want 0", bus.first_fail_idx); end
      checks++; if (bus.compare_fail !== 1'b0) begin errors++; $display("FAIL rst_compare_fail got %0b want 0", bus.compare_fail); end
      rst = 1'b0;
   endtask

   task automatic test_good_pattern();
      logic cf;
      for (int i = 0; i < SL; i++) begin
         checks++; if (bus.exp_idx !== 5'(i)) begin errors++; $display("FAIL good_exp_idx got %0d want %0d", bus.exp_idx, i); end
         send_word(4'd3, i, 1'b0);
      end
      checks++; if (bus.exp_idx !== 5'd16) begin errors++; $display("FAIL good_full_idx got %0d want 16", bus.exp_idx); end
      do_compare(4'd3, 1'b0, cf);
      checks++; if (cf !== 1'b0) begin errors++; $display("FAIL good_compare_fail got %0b want 0", cf); end
      checks++; if (bus.fail_cnt !== 8'd0) begin errors++; $display("FAIL good_fail_cnt got %0d want 0", bus.fail_cnt); end
      checks++; if (bus.fail_seen !== 1'b0) begin errors++; $display("FAIL good_fail_seen got %0b want 0", bus.fail_seen); end
      checks++; if (bus.exp_idx !== 5'd0) begin errors++; $display("FAIL good_idx_cleared got %0d want 0", bus.exp_idx); end
   endtask

   task automatic test_mismatch();
      logic cf;
      for (int i = 0; i < SL; i++) send_word(4'd2, i, (i == 5) || (i == 9));
      do_compare(4'd2, 1'b0, cf);
      checks++; if (cf !== 1'b1) begin errors++; $display("FAIL mm_compare_fail got %0b want 1", cf); end
      checks++; if (bus.fail_cnt !== 8'd1) begin errors++; $display("FAIL mm_fail_cnt got %0d want 1", bus.fail_cnt); end
      checks++; if (bus.fail_seen !== 1'b1) begin errors++; $display("FAIL mm_fail_seen got %0b want 1", bus.fail_seen); end
      checks++; if (bus.first_fail_addr !== 4'd2) begin errors++; $display("FAIL mm_first_addr got %0d want 2", bus.first_fail_addr); end
      checks++; if (bus.first_fail_idx !== 5'd5) begin errors++; $display("FAIL mm_first_idx got %0d want 5", bus.first_fail_idx); end
   endtask

   task automatic test_last_word();
      logic cf;
      do_clr();
      for (int i = 0; i < SL; i++) send_word(4'd4, i, i == 15);
      do_compare(4'd4, 1'b0, cf);
      checks++; if (cf !== 1'b1) begin errors++; $display("FAIL last_compare_fail got %0b want 1", cf); end
      checks++; if (bus.first_fail_idx !== 5'd15) begin errors++; $display("FAIL last_first_idx got %0d want 15", bus.first_fail_idx); end
      checks++; if (bus.first_fail_addr !== 4'd4) begin errors++; $display("FAIL last_first_addr got %0d want 4", bus.first_fail_addr); end
   endtask

   task automatic test_count_errors();
      logic cf;
      do_clr();
      for (int i = 0; i < 15; i++) send_word(4'd6, i, 1'b0);
      do_compare(4'd6, 1'b0, cf);
      checks++; if (cf !== 1'b1) begin errors++; $display("FAIL short_compare_fail got %0b want 1", cf); end
      checks++; if (bus.first_fail_idx !== 5'd16) begin errors++; $display("FAIL short_first_idx got %0d want 16", bus.first_fail_idx); end
      for (int i = 0; i < 17; i++) send_word(4'd7, i, 1'b0);
      checks++; if (bus.exp_idx !== 5'd16) begin errors++; $display("FAIL over_idx_hold got %0d want 16", bus.exp_idx); end
      do_compare(4'd7, 1'b0, cf);
      checks++; if (cf !== 1'b1) begin errors++; $display("FAIL over_compare_fail got %0b want 1", cf); end
      checks++; if (bus.fail_cnt !== 8'd2) begin errors++; $display("FAIL over_fail_cnt got %0d want 2", bus.fail_cnt); end
      checks++; if (bus.first_fail_addr !== 4'd6) begin errors++; $display("FAIL over_first_addr_hold got %0d want 6", bus.first_fail_addr); end
   endtask

   task automatic test_compare_with_valid();
      logic cf;
      do_clr();
      for (int i = 0; i < SL; i++) send_word(4'd8, i, 1'b0);
      do_compare(4'd8, 1'b1, cf);
      checks++; if (cf !== 1'b1) begin errors++; $display("FAIL cv_compare_fail got %0b want 1", cf); end
      checks++; if (bus.first_fail_idx !== 5'd16) begin errors++; $display("FAIL cv_first_idx got %0d want 16", bus.first_fail_idx); end
      checks++; if (bus.exp_idx !== 5'd0) begin errors++; $display("FAIL cv_idx_cleared got %0d want 0", bus.exp_idx); end
   endtask

   task automatic test_empty_compare();
      logic cf;
      do_clr();
      do_compare(4'd11, 1'b0, cf);
      checks++; if (cf !== 1'b1) begin errors++; $display("FAIL empty_compare_fail got %0b want 1", cf); end
      checks++; if (bus.first_fail_idx !== 5'd16) begin errors++; $display("FAIL empty_first_idx got %0d want 16", bus.first_fail_idx); end
      checks++; if (bus.first_fail_addr !== 4'd11) begin errors++; $display("FAIL empty_first_addr got %0d want 11", bus.first_fail_addr); end
   endtask

   task automatic test_saturation();
      logic cf;
      do_clr();
      for (int i = 0; i < 300; i++) begin
         do_compare(4'((i + 9) % 16), 1'b0, cf);
         if (i == 253) begin
            checks++; if (bus.fail_cnt !== 8'd254) begin errors++; $display("FAIL sat_cnt_254 got %0d want 254", bus.fail_cnt); end
         end
      end
      checks++; if (bus.fail_cnt !== 8'd255) begin errors++; $display("FAIL sat_fail_cnt got %0d want 255", bus.fail_cnt); end
      checks++; if (bus.first_fail_addr !== 4'd9) begin errors++; $display("FAIL sat_first_addr got %0d want 9", bus.first_fail_addr); end
      checks++; if (bus.first_fail_idx !== 5'd16) begin errors++; $display("FAIL sat_first_idx got %0d want 16", bus.first_fail_idx); end
      send_word(4'd1, 0, 1'b1);
      // clr must win over a simultaneous compare and word
      @(negedge clk);
      bus.clr = 1'b1; bus.compare = 1'b1; bus.out_valid = 1'b1;
      @(posedge clk);
      #1 bus.clr = 1'b0; bus.compare = 1'b0; bus.out_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.fail_cnt !== 8'd0) begin errors++; $display("FAIL clr_fail_cnt got %0d want 0", bus.fail_cnt); end
      checks++; if (bus.fail_seen !== 1'b0) begin errors++; $display("FAIL clr_fail_seen got %0b want 0", bus.fail_seen); end
      checks++; if (bus.first_fail_addr !== 4'd0) begin errors++; $display("FAIL clr_first_addr got %0d want 0", bus.first_fail_addr); end
      checks++; if (bus.first_fail_idx !== 5'd0) begin errors++; $display("FAIL clr_first_idx got %0d want 0", bus.first_fail_idx); end
      checks++; if (bus.exp_idx !== 5'd0) begin errors++; $display("FAIL clr_exp_idx got %0d want 0", bus.exp_idx); end
   endtask

   task automatic test_rst_mid_collect();
      logic cf;
      for (int i = 0; i < 7; i++) send_word(4'd1, i, i == 3);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.exp_idx !== 5'd0) begin errors++; $display("FAIL rstmid_exp_idx got %0d want 0", bus.exp_idx); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < SL; i++) send_word(4'd1, i, 1'b0);
      do_compare(4'd1, 1'b0, cf);
      checks++; if (cf !== 1'b0) begin errors++; $display("FAIL rstmid_compare_fail got %0b want 0", cf); end
      checks++; if (bus.fail_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_fail_cnt got %0d want 0", bus.fail_cnt); end
      checks++; if (bus.fail_seen !== 1'b0) begin errors++; $display("FAIL rstmid_fail_seen got %0b want 0", bus.fail_seen); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_good_pattern();
      test_mismatch();
      test_last_word();
      test_count_errors();
      test_compare_with_valid();
      test_empty_compare();
      test_saturation();
      test_rst_mid_collect();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
